// File: rtl/hpdcache_wbuf_mem_adapter_if.sv
// Bus bundle between the write buffer, the adapter and the memory write channels.
// The adapter uses the slave view; the write buffer / memory side uses master.
interface hpdcache_wbuf_mem_adapter_if #(
    parameter int WBUF_DATA_W = 128,
    parameter int MEM_DATA_W  = 512,
    parameter int PA_W        = 49,
    parameter int WBUF_ID_W   = 2,
    parameter int MEM_ID_W    = 6
);
    logic                      send_meta_valid_i;
    logic                      send_meta_ready_o;
    logic [PA_W-1:0]           send_addr_i;
    logic [WBUF_ID_W-1:0]      send_id_i;
    logic                      send_uc_i;
    logic                      send_data_valid_i;
    logic                      send_data_ready_o;
    logic [PA_W-1:0]           send_data_tag_i;
    logic [WBUF_DATA_W-1:0]    send_data_i;
    logic [WBUF_DATA_W/8-1:0]  send_be_i;
    logic                      ack_o;
    logic [WBUF_ID_W-1:0]      ack_id_o;
    logic                      ack_error_o;
    logic                      mem_req_valid_o;
    logic                      mem_req_ready_i;
    logic [PA_W-1:0]           mem_req_addr_o;
    logic [MEM_ID_W-1:0]       mem_req_id_o;
    logic [2:0]                mem_req_size_o;
    logic                      mem_req_cacheable_o;
    logic                      mem_req_w_valid_o;
    logic                      mem_req_w_ready_i;
    logic [MEM_DATA_W-1:0]     mem_req_w_data_o;
    logic [MEM_DATA_W/8-1:0]   mem_req_w_be_o;
    logic                      mem_req_w_last_o;
    logic                      mem_resp_w_valid_i;
    logic                      mem_resp_w_ready_o;
    logic [MEM_ID_W-1:0]       mem_resp_w_id_i;
    logic                      mem_resp_w_error_i;

    modport slave (
        input  send_meta_valid_i, send_addr_i, send_id_i, send_uc_i,
        input  send_data_valid_i, send_data_tag_i, send_data_i, send_be_i,
        input  mem_req_ready_i, mem_req_w_ready_i,
        input  mem_resp_w_valid_i, mem_resp_w_id_i, mem_resp_w_error_i,
        output send_meta_ready_o, send_data_ready_o,
        output ack_o, ack_id_o, ack_error_o,
        output mem_req_valid_o, mem_req_addr_o, mem_req_id_o, mem_req_size_o, mem_req_cacheable_o,
        output mem_req_w_valid_o, mem_req_w_data_o, mem_req_w_be_o, mem_req_w_last_o,
        output mem_resp_w_ready_o
    );

    modport master (
        output send_meta_valid_i, send_addr_i, send_id_i, send_uc_i,
        output send_data_valid_i, send_data_tag_i, send_data_i, send_be_i,
        output mem_req_ready_i, mem_req_w_ready_i,
        output mem_resp_w_valid_i, mem_resp_w_id_i, mem_resp_w_error_i,
        input  send_meta_ready_o, send_data_ready_o,
        input  ack_o, ack_id_o, ack_error_o,
        input  mem_req_valid_o, mem_req_addr_o, mem_req_id_o, mem_req_size_o, mem_req_cacheable_o,
        input  mem_req_w_valid_o, mem_req_w_data_o, mem_req_w_be_o, mem_req_w_last_o,
        input  mem_resp_w_ready_o
    );
endinterface

// File: rtl/hpdcache_wbuf_mem_adapter.sv
// Write-buffer to memory write-channel adapter: combinational meta forwarding,
// per-ID in-flight scoreboard with runtime limit, one-slot upsizing data stage.
module hpdcache_wbuf_mem_adapter #(
    parameter int WBUF_DATA_W = 128,
    parameter int MEM_DATA_W  = 512,
    parameter int PA_W        = 49,
    parameter int WBUF_ID_W   = 2,
    parameter int MEM_ID_W    = 6,
    parameter int ID_PREFIX   = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WBUF_ID_W:0]   cfg_max_outstanding_i,
    output logic [WBUF_ID_W:0]   inflight_cnt_o,
    output logic                 idle_o,
    output logic                 unexp_ack_o,
    hpdcache_wbuf_mem_adapter_if.slave bus
);
    localparam int NID    = 2 ** WBUF_ID_W;
    localparam int CNT_W  = WBUF_ID_W + 1;
    localparam int R      = MEM_DATA_W / WBUF_DATA_W;
    localparam int OFF_W  = $clog2(WBUF_DATA_W / 8);
    localparam int IDX_WS = (R > 1) ? $clog2(R) : 1;
    localparam int BE_W   = WBUF_DATA_W / 8;
    localparam int PFX_W  = MEM_ID_W - WBUF_ID_W;

    logic [NID-1:0]          busy_q, busy_d, set_vec, clr_vec;
    logic [CNT_W-1:0]        cnt_q, cnt_d, limit;
    logic                    meta_ok, meta_fire, hit;
    logic [WBUF_ID_W-1:0]    resp_id;
    logic                    dv_q, data_fire;
    logic [MEM_DATA_W-1:0]   w_data_q, w_data_d;
    logic [MEM_DATA_W/8-1:0] w_be_q, w_be_d;
    logic [IDX_WS-1:0]       idx;
    logic                    unexp_q;

    // Zero and out-of-range limits both mean "all IDs may be in flight".
    assign limit = (cfg_max_outstanding_i == '0 || cfg_max_outstanding_i > CNT_W'(NID))
                   ? CNT_W'(NID) : cfg_max_outstanding_i;

    assign meta_ok   = (cnt_q < limit) && !busy_q[bus.send_id_i];
    assign meta_fire = bus.send_meta_valid_i && bus.mem_req_ready_i && meta_ok;

    assign bus.mem_req_valid_o     = bus.send_meta_valid_i && meta_ok;
    assign bus.send_meta_ready_o   = bus.mem_req_ready_i && meta_ok;
    assign bus.mem_req_addr_o      = bus.send_addr_i;
    assign bus.mem_req_id_o        = {PFX_W'(ID_PREFIX), bus.send_id_i};
    assign bus.mem_req_size_o      = 3'(OFF_W);
    assign bus.mem_req_cacheable_o = ~bus.send_uc_i;

    assign resp_id = bus.mem_resp_w_id_i[WBUF_ID_W-1:0];
    assign hit     = bus.mem_resp_w_valid_i
                  && (bus.mem_resp_w_id_i[MEM_ID_W-1:WBUF_ID_W] == PFX_W'(ID_PREFIX))
                  && busy_q[resp_id];

    assign bus.ack_o              = hit;
    assign bus.ack_id_o           = resp_id;
    assign bus.ack_error_o        = bus.mem_resp_w_error_i;
    assign bus.mem_resp_w_ready_o = 1'b1;

    // Set and clear never target the same ID: a busy ID cannot be issued.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        set_vec = '0;
        clr_vec = '0;
        if (meta_fire) set_vec[bus.send_id_i] = 1'b1;
        if (hit)       clr_vec[resp_id]       = 1'b1;
        busy_d = (busy_q | set_vec) & ~clr_vec;
        cnt_d  = cnt_q + CNT_W'(meta_fire) - CNT_W'(hit);
    end

    assign bus.send_data_ready_o = !dv_q || bus.mem_req_w_ready_i;
    assign data_fire = bus.send_data_valid_i && bus.send_data_ready_o;
    assign idx = (R > 1) ? bus.send_data_tag_i[OFF_W +: IDX_WS] : '0;

    always_comb begin
        w_data_d = {R{bus.send_data_i}};
        w_be_d   = '0;
        for (int i = 0; i < R; i++) begin
            if (IDX_WS'(i) == idx) w_be_d[i*BE_W +: BE_W] = bus.send_be_i;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst_i) begin
            busy_q  <= '0;
            cnt_q   <= '0;
            unexp_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            if (bus.mem_resp_w_valid_i && !hit) unexp_q <= 1'b1;
        end
    end

    // The data slot is reset too so the write channel shows zeros after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dv_q     <= 1'b0;
            w_data_q <= '0;
            w_be_q   <= '0;
        end else if (data_fire) begin
            dv_q     <= 1'b1;
            w_data_q <= w_data_d;
            w_be_q   <= w_be_d;
        end else if (bus.mem_req_w_ready_i) begin
            dv_q     <= 1'b0;
        end
    end

    assign bus.mem_req_w_valid_o = dv_q;
    assign bus.mem_req_w_data_o  = w_data_q;
    assign bus.mem_req_w_be_o    = w_be_q;
    assign bus.mem_req_w_last_o  = 1'b1;

    assign inflight_cnt_o = cnt_q;
    assign idle_o         = (cnt_q == '0) && !dv_q;
    assign unexp_ack_o    = unexp_q;
endmodule

// File: tb/tb_hpdcache_wbuf_mem_adapter.sv
// Directed bench for hpdcache_wbuf_mem_adapter with a non-zero ID prefix.
module tb_hpdcache_wbuf_mem_adapter;
    localparam int WBUF_DATA_W = 128;
    localparam int MEM_DATA_W  = 512;
    localparam int PA_W        = 49;
    localparam int WBUF_ID_W   = 2;
    localparam int MEM_ID_W    = 6;
    localparam int ID_PREFIX   = 5;

    logic clk = 1'b0;
    logic rst_i;
    logic [WBUF_ID_W:0] cfg_max_outstanding_i;
    logic [WBUF_ID_W:0] inflight_cnt_o;
    logic idle_o, unexp_ack_o;
    int n_pass = 0;
    int n_chk  = 0;

    hpdcache_wbuf_mem_adapter_if #(
        .WBUF_DATA_W(WBUF_DATA_W), .MEM_DATA_W(MEM_DATA_W), .PA_W(PA_W),
        .WBUF_ID_W(WBUF_ID_W), .MEM_ID_W(MEM_ID_W)
    ) bus ();

    hpdcache_wbuf_mem_adapter #(
        .WBUF_DATA_W(WBUF_DATA_W), .MEM_DATA_W(MEM_DATA_W), .PA_W(PA_W),
        .WBUF_ID_W(WBUF_ID_W), .MEM_ID_W(MEM_ID_W), .ID_PREFIX(ID_PREFIX)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .cfg_max_outstanding_i(cfg_max_outstanding_i),
        .inflight_cnt_o(inflight_cnt_o),
        .idle_o(idle_o),
        .unexp_ack_o(unexp_ack_o),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resp(input logic [MEM_ID_W-1:0] id, input logic err);
        bus.mem_resp_w_valid_i = 1'b1;
        bus.mem_resp_w_id_i    = id;
        bus.mem_resp_w_error_i = err;
    endtask

    initial begin
        rst_i                  = 1'b1;
        cfg_max_outstanding_i  = '0;
        bus.send_meta_valid_i  = 1'b0;
        bus.send_addr_i        = 49'h1_2345_6780;
        bus.send_id_i          = '0;
        bus.send_uc_i          = 1'b1;
        bus.send_data_valid_i  = 1'b0;
        bus.send_data_tag_i    = '0;
        bus.send_data_i        = '0;
        bus.send_be_i          = '0;
        bus.mem_req_ready_i    = 1'b1;
        bus.mem_req_w_ready_i  = 1'b0;
        bus.mem_resp_w_valid_i = 1'b0;
        bus.mem_resp_w_id_i    = '0;
        bus.mem_resp_w_error_i = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_cnt", inflight_cnt_o, 0);
        check("rst_wvalid", bus.mem_req_w_valid_o, 0);
        check("rst_be", bus.mem_req_w_be_o, 0);
        check("rst_data", bus.mem_req_w_data_o, 0);
        check("rst_unexp", unexp_ack_o, 0);
        check("rst_idle", idle_o, 1);
        check("resp_ready", bus.mem_resp_w_ready_o, 1);
        rst_i = 1'b0;
        tick();

        // Upsizing and lane select: tag 0x1020 -> lane 2
        bus.send_data_valid_i = 1'b1;
        bus.send_data_i       = {16{8'hA5}};
        bus.send_be_i         = 16'hFFFF;
        bus.send_data_tag_i   = 49'h1020;
        #1 check("dready_empty", bus.send_data_ready_o, 1);
        tick();
        bus.send_data_i     = {16{8'hB6}};
        bus.send_be_i       = 16'h00F0;
        bus.send_data_tag_i = 49'h1000;
        #1;
        check("up_valid", bus.mem_req_w_valid_o, 1);
        check("up_be", bus.mem_req_w_be_o, 64'h0000_FFFF_0000_0000);
        check("up_data", bus.mem_req_w_data_o, {64{8'hA5}});
        check("up_last", bus.mem_req_w_last_o, 1);
        check("up_idle", idle_o, 0);

        // Data backpressure: slot full, ready low for 5 cycles
        for (int i = 0; i < 5; i++) begin
            check("bp_dready", bus.send_data_ready_o, 0);
            check("bp_valid", bus.mem_req_w_valid_o, 1);
            check("bp_be", bus.mem_req_w_be_o, 64'h0000_FFFF_0000_0000);
            check("bp_data", bus.mem_req_w_data_o, {64{8'hA5}});
            tick();
        end
        bus.mem_req_w_ready_i = 1'b1;
        #1 check("bp_release", bus.send_data_ready_o, 1);
        tick();
        bus.send_data_valid_i = 1'b0;
        #1;
        check("bp_next_valid", bus.mem_req_w_valid_o, 1);
        check("bp_next_be", bus.mem_req_w_be_o, 64'h0000_0000_0000_00F0);
        check("bp_next_data", bus.mem_req_w_data_o, {64{8'hB6}});
        tick();
        check("drain_valid", bus.mem_req_w_valid_o, 0);
        check("drain_idle", idle_o, 1);

        // Outstanding limit of 2: IDs 0, 1, 2 back-to-back
        cfg_max_outstanding_i = 3'd2;
        bus.send_meta_valid_i = 1'b1;
        bus.send_id_i         = 2'd0;
        #1;
        check("meta_valid0", bus.mem_req_valid_o, 1);
        check("meta_ready0", bus.send_meta_ready_o, 1);
        check("meta_id0", bus.mem_req_id_o, 6'h14);
        check("meta_size", bus.mem_req_size_o, 4);
        check("meta_cacheable", bus.mem_req_cacheable_o, 0);
        check("meta_addr", bus.mem_req_addr_o, 49'h1_2345_6780);
        tick();
        bus.send_id_i = 2'd1;
        bus.send_uc_i = 1'b0;
        #1;
        check("meta_valid1", bus.mem_req_valid_o, 1);
        check("meta_cacheable1", bus.mem_req_cacheable_o, 1);
        tick();
        bus.send_id_i = 2'd2;
        #1;
        check("full_cnt", inflight_cnt_o, 2);
        check("full_valid", bus.mem_req_valid_o, 0);
        check("full_ready", bus.send_meta_ready_o, 0);
        tick();
        check("full_hold", bus.mem_req_valid_o, 0);
        resp(6'h14, 1'b0);
        #1;
        check("ack0", bus.ack_o, 1);
        check("ack0_id", bus.ack_id_o, 0);
        check("ack0_err", bus.ack_error_o, 0);
        check("ack0_no_comb_release", bus.mem_req_valid_o, 0);
        tick();
        bus.mem_resp_w_valid_i = 1'b0;
        #1;
        check("after_ack_cnt", inflight_cnt_o, 1);
        check("id2_issue", bus.mem_req_valid_o, 1);
        check("id2_id", bus.mem_req_id_o, 6'h16);
        tick();
        bus.send_meta_valid_i = 1'b0;
        check("limit_cnt_back", inflight_cnt_o, 2);

        // ID reuse blocking: ID 1 busy, limit raised to all IDs
        cfg_max_outstanding_i = 3'd0;
        bus.send_meta_valid_i = 1'b1;
        bus.send_id_i         = 2'd1;
        #1;
        check("reuse_ready", bus.send_meta_ready_o, 0);
        check("reuse_valid", bus.mem_req_valid_o, 0);
        tick();
        check("reuse_hold", bus.send_meta_ready_o, 0);
        resp(6'h15, 1'b0);
        #1;
        check("ack1", bus.ack_o, 1);
        check("ack1_id", bus.ack_id_o, 1);
        check("reuse_same_cycle", bus.send_meta_ready_o, 0);
        tick();
        bus.mem_resp_w_valid_i = 1'b0;
        #1;
        check("reuse_free", bus.send_meta_ready_o, 1);
        check("reuse_cnt", inflight_cnt_o, 1);
        tick();
        check("reuse_issued_cnt", inflight_cnt_o, 2);

        // Simultaneous issue of ID 3 and ack of ID 2
        bus.send_id_i = 2'd3;
        resp(6'h16, 1'b0);
        #1;
        check("sim_ack", bus.ack_o, 1);
        check("sim_issue", bus.mem_req_valid_o, 1);
        tick();
        bus.send_meta_valid_i  = 1'b0;
        bus.mem_resp_w_valid_i = 1'b0;
        #1 check("sim_cnt", inflight_cnt_o, 2);

        // Error response for busy ID 3, then repeat (unexpected)
        resp(6'h17, 1'b1);
        #1;
        check("err_ack", bus.ack_o, 1);
        check("err_id", bus.ack_id_o, 3);
        check("err_flag", bus.ack_error_o, 1);
        check("err_unexp", unexp_ack_o, 0);
        tick();
        resp(6'h17, 1'b0);
        #1 check("dup_ack", bus.ack_o, 0);
        tick();
        bus.mem_resp_w_valid_i = 1'b0;
        check("dup_unexp", unexp_ack_o, 1);
        check("dup_cnt", inflight_cnt_o, 1);

        // Reset with 3 writes in flight (ID 1 plus IDs 0, 2)
        bus.send_meta_valid_i = 1'b1;
        bus.send_id_i         = 2'd0;
        tick();
        bus.send_id_i = 2'd2;
        tick();
        bus.send_meta_valid_i = 1'b0;
        check("pre_rst_cnt", inflight_cnt_o, 3);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_cnt", inflight_cnt_o, 0);
        check("mid_rst_idle", idle_o, 1);
        check("mid_rst_unexp", unexp_ack_o, 0);

        // Stale response after reset is unexpected
        resp(6'h14, 1'b0);
        #1 check("stale_ack", bus.ack_o, 0);
        tick();
        bus.mem_resp_w_valid_i = 1'b0;
        check("stale_unexp", unexp_ack_o, 1);

        // Wrong prefix on a busy ID
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        bus.send_meta_valid_i = 1'b1;
        bus.send_id_i         = 2'd0;
        tick();
        bus.send_meta_valid_i = 1'b0;
        resp(6'h10, 1'b0);
        #1 check("pfx_ack", bus.ack_o, 0);
        tick();
        bus.mem_resp_w_valid_i = 1'b0;
        check("pfx_unexp", unexp_ack_o, 1);
        check("pfx_cnt", inflight_cnt_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
